lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit between the datapath and data memory. Takes ALUResult, writeData, f3 and
//  memRead/memWrite, runs a req/ack bus transaction, and returns aligned, extended load data
//  as readData. Asserts stall to freeze PC and register writes while an access is in flight.
// PARAMETERS
//  ADDR_W   16   bus address width, taken from addr[ADDR_W-1:0]
//  TIMEOUT  255  max BUS-state cycles without ack before abort (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  mem_read   in   1       load request from control unit
//  mem_write  in   1       store request from control unit
//  f3         in   3       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr       in   32      byte address (ALUResult)
//  wdata      in   32      store data (writeData)
//  rdata      out  32      load result to datapath (readData)
//  stall      out  1       1 = hold PC and suppress regWrite this cycle
//  misalign   out  1       1-cycle pulse, misaligned access rejected
//  bus_err    out  1       sticky, set on timeout, cleared only by rst
//  bus_req    out  1       bus request, held until ack
//  bus_we     out  1       1 = write
//  bus_addr   out  ADDR_W  word-aligned address, bits [1:0] = 0
//  bus_wdata  out  32      lane-replicated store data
//  bus_be     out  4       byte enables, bit i = byte lane i
//  bus_rdata  in   32      read word from memory
//  bus_ack    in   1       transaction complete, 1 cycle
// BEHAVIOUR
//  Reset values: state IDLE; rdata, bus_req, bus_we, bus_addr, bus_wdata, bus_be, misalign,
//   bus_err and the timeout counter all 0. stall is 0 in IDLE when there is no request.
//  States: IDLE -> BUS -> DONE -> IDLE.
//  IDLE: request = mem_read|mem_write.
//   - Aligned request: latch addr, f3, wdata and op, go to BUS, drive stall=1 combinationally.
//   - Both mem_read and mem_write high: treated as a store.
//   - Misaligned request (H with addr[0]=1, W with addr[1:0]!=0): stay in IDLE, no bus access,
//     stall=0, misalign=1 for this cycle only, rdata=0.
//   - f3[1:0]=11: treated as W.
//  BUS: bus_req=1, stall=1. bus_we/addr/wdata/be come from registers and stay stable until ack.
//   Counter increments each BUS cycle.
//   - On bus_ack: load result is registered into rdata, go to DONE.
//   - Counter reaches TIMEOUT with no ack: drop bus_req, set bus_err, rdata=0, go to DONE.
//     A store is lost.
//  DONE: stall=0, bus_req=0, rdata valid; the core commits at the end of this cycle.
//   Always returns to IDLE; the still-asserted request is not re-sampled.
//  Latency: request in cycle 0, bus_req in cycles 1..k with ack in cycle k, DONE in k+1.
//   Minimum stall is 2 cycles.
//  Store lanes:
//   - SB: be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}
//   - SH: be = 4'b0011 << {addr[1],1'b0}, wdata = {2{wdata[15:0]}}
//   - SW: be = 4'hF
//  Loads: be=4'hF. Select the byte/half lane by addr[1:0]. Sign-extend when f3[2]=0,
//   zero-extend when f3[2]=1.
//  rdata holds its value until the next DONE; it is 0 after a store.
//  rst asserted in any state, including mid-BUS: immediate return to IDLE, all outputs to
//   reset values, and the in-flight transaction is abandoned. The memory must ignore a
//   dropped req.
// TESTING
//  1. LW addr 0x0010, ack on 3rd BUS cycle, bus_rdata 0x12345678 -> bus_addr 0x0010, be F,
//     rdata 0x12345678, stall high 4 cycles.
//  2. LB addr 0x0003, bus_rdata 0x80AABBCC -> rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  3. SH addr 0x0006, wdata 0x1234BEEF -> bus_we 1, bus_addr 0x0004, be 1100,
//     bus_wdata 0xBEEFBEEF.
//  4. LW addr 0x0006 -> misalign 1 pulse, bus_req never asserted, stall 0.
//  5. LW with no ack, TIMEOUT=4 -> bus_req low after 4 BUS cycles, bus_err=1 sticky,
//     rdata 0, DONE reached.
//  6. rst pulse mid-BUS -> bus_req, stall and bus_err 0 immediately; next request starts cleanly.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns datapath load/store requests into a single req/ack bus
// transaction, steering store lanes and aligning/extending load data.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for mem_read/mem_write; rejects misaligned requests
// BUS   | bus_req held, counting cycles until ack or timeout
// DONE  | result valid in rdata, stall released, core commits
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        f3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic              req, is_word, is_half, mis, accept, timeout_hit;
  logic [3:0]        be_nx;
  logic [31:0]       wdata_nx;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W];

  // f3[1:0]=1x is a word access, so 011 and 111 fall through as W.
  always_comb begin
    req         = mem_read | mem_write;
    is_word     = f3[1];
    is_half     = (f3[1:0] == 2'b01);
    mis         = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    accept      = 1'b0;
    stall       = 1'b0;
    misalign    = 1'b0;
    bus_req     = 1'b0;
    state_nx    = state;
    case (state)
      S_IDLE: begin
        if (req && !rst) begin
          if (mis) begin
            misalign = 1'b1;
          end else begin
            accept   = 1'b1;
            stall    = 1'b1;
            state_nx = S_BUS;
          end
        end
      end
      S_BUS: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (bus_ack || timeout_hit) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    be_nx    = 4'hF;
    wdata_nx = wdata;
    if (mem_write) begin
      case (f3[1:0])
        2'b00: begin
          be_nx    = 4'b0001 << addr[1:0];
          wdata_nx = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_nx    = 4'b0011 << {addr[1], 1'b0};
          wdata_nx = {2{wdata[15:0]}};
        end
        default: begin
          be_nx    = 4'hF;
          wdata_nx = wdata;
        end
      endcase
    end
  end

  // f3_q[2] set means unsigned load.
  always_comb begin
    byte_sel = bus_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_val = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
      rdata     <= '0;
      bus_err   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_BUS) cnt <= cnt + CNT_W'(1);
      else                cnt <= '0;
      if (accept) begin
        bus_we    <= mem_write;
        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
        bus_wdata <= wdata_nx;
        bus_be    <= be_nx;
        f3_q      <= f3;
        lane_q    <= addr[1:0];
      end
      if (misalign) rdata <= '0;
      // A timed-out store is dropped; the memory never saw an ack for it.
      if (state == S_BUS) begin
        if (bus_ack) begin
          rdata <= bus_we ? 32'd0 : load_val;
        end else if (timeout_hit) begin
          rdata   <= '0;
          bus_err <= 1'b1;
        end
      end
    end
  end

endmodule
